// File: rtl/apb_regs_pkg.sv
// Shared encodings for the APB completer register block: FSM states, select decodes, status width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_regs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [1:0] WSEL_PAYLOAD0  = 2'd0;
    localparam logic [1:0] WSEL_PAYLOAD1  = 2'd1;
    localparam logic [1:0] WSEL_DATA_SIZE = 2'd2;

    localparam logic [1:0] RSEL_ERR_STATUS = 2'd0;
    localparam logic [1:0] RSEL_PAYLOAD0   = 2'd1;
    localparam logic [1:0] RSEL_PAYLOAD1   = 2'd2;
    localparam logic [1:0] RSEL_DATA_SIZE  = 2'd3;

    localparam int ERR_W = 8;

endpackage

// File: rtl/apb_wait_counter.sv
// ACCESS-phase wait-state counter: loads WAIT_CYCLES in SETUP, counts down through ACCESS.
// Latency: zero_o rises WAIT_CYCLES cycles after ACCESS entry.
// Backpressure: zero_o low holds the transfer in ACCESS; IDLE clears the count.
module apb_wait_counter
    import apb_regs_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       pclk,
    input  logic       preset,
    input  apb_state_e state_i,
    output logic       zero_o
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case (state_i)
            SETUP:   cnt_d = CW'(WAIT_CYCLES);
            ACCESS:  if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer register block: payload0/1, data_size, sticky clear-on-read err_status.
// Latency: 2 cycles per transfer (SETUP, ACCESS), plus WAIT_CYCLES when APB_WAIT_STATES_EN is defined.
// Backpressure: pready low during wait states; psel dropped before pready aborts with no commit.
module apb_completer_regs
    import apb_regs_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int WAIT_CYCLES   = 2,
    parameter int MAX_DATA_SIZE = 8
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [1:0]            write_select,
    input  logic [1:0]            read_select,
    input  logic                  map_err,
    input  logic [ERR_W-1:0]      err_set,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] payload0,
    output logic [DATA_WIDTH-1:0] payload1,
    output logic [7:0]            data_size
);

    apb_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] payload0_q, payload0_d;
    logic [DATA_WIDTH-1:0] payload1_q, payload1_d;
    logic [7:0]            data_size_q, data_size_d;
    logic [ERR_W-1:0]      err_status_q, err_status_d;

    logic wait_zero;
    logic complete;
    logic size_err;
    logic commit;
    logic rd_ok;
    logic rd_clr;

`ifdef APB_WAIT_STATES_EN
    apb_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .pclk    (pclk),
        .preset  (preset),
        .state_i (state_q),
        .zero_o  (wait_zero)
    );
`else
    logic unused_wait_cfg;
    assign wait_zero       = 1'b1;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (psel && !penable) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (wait_zero) begin
                    state_d = (psel && !penable) ? SETUP : IDLE;
                end else if (!psel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready   = (state_q == ACCESS) && wait_zero;
    assign complete = pready;
    assign size_err = complete && pwrite && (write_select == WSEL_DATA_SIZE)
                      && (pwdata > DATA_WIDTH'(MAX_DATA_SIZE));
    assign pslverr  = complete && (map_err || size_err);
    assign commit   = complete && pwrite && !map_err && !size_err;
    assign rd_ok    = complete && !pwrite && !map_err;
    assign rd_clr   = rd_ok && (read_select == RSEL_ERR_STATUS);

    always_comb begin
        payload0_d  = payload0_q;
        payload1_d  = payload1_q;
        data_size_d = data_size_q;
        if (commit) begin
            case (write_select)
                WSEL_PAYLOAD0:  payload0_d  = pwdata;
                WSEL_PAYLOAD1:  payload1_d  = pwdata;
                WSEL_DATA_SIZE: data_size_d = pwdata[7:0];
                default: ;
            endcase
        end
        // Pulsed bits survive a same-cycle clear-on-read.
        err_status_d = (rd_clr ? '0 : err_status_q) | err_set;
    end

    always_comb begin
        prdata = '0;
        if (rd_ok) begin
            case (read_select)
                RSEL_ERR_STATUS: prdata = DATA_WIDTH'(err_status_q);
                RSEL_PAYLOAD0:   prdata = payload0_q;
                RSEL_PAYLOAD1:   prdata = payload1_q;
                default:         prdata = DATA_WIDTH'(data_size_q);
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            payload0_q   <= '0;
            payload1_q   <= '0;
            data_size_q  <= '0;
            err_status_q <= '0;
        end else begin
            state_q      <= state_d;
            payload0_q   <= payload0_d;
            payload1_q   <= payload1_d;
            data_size_q  <= data_size_d;
            err_status_q <= err_status_d;
        end
    end

    assign payload0  = payload0_q;
    assign payload1  = payload1_q;
    assign data_size = data_size_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Randomized bench for apb_completer_regs against a register-map model; honours APB_WAIT_STATES_EN.
// Inputs change and outputs are sampled on the falling edge.
module tb_apb_completer_regs;

    localparam int DW   = 32;
    localparam int WC   = 2;
    localparam int MAXS = 8;
`ifdef APB_WAIT_STATES_EN
    localparam int EXP_WAIT = WC;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic          pclk;
    logic          preset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [1:0]    write_select;
    logic [1:0]    read_select;
    logic          map_err;
    logic [7:0]    err_set;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [DW-1:0] payload0;
    logic [DW-1:0] payload1;
    logic [7:0]    data_size;

    apb_completer_regs #(
        .DATA_WIDTH    (DW),
        .WAIT_CYCLES   (WC),
        .MAX_DATA_SIZE (MAXS)
    ) dut (
        .pclk         (pclk),
        .preset       (preset),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .write_select (write_select),
        .read_select  (read_select),
        .map_err      (map_err),
        .err_set      (err_set),
        .pready       (pready),
        .prdata       (prdata),
        .pslverr      (pslverr),
        .payload0     (payload0),
        .payload1     (payload1),
        .data_size    (data_size)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference register map
    logic [31:0] m_p0, m_p1;
    logic [7:0]  m_ds, m_err;
    bit          rand_err;

    int n_cmp;
    int n_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [1:0] rsel);
        case (rsel)
            2'd0:    return {24'd0, m_err};
            2'd1:    return m_p0;
            2'd2:    return m_p1;
            default: return {24'd0, m_ds};
        endcase
    endfunction

    task automatic tick(input bit clr);
        logic [7:0] nxt;
        nxt = (clr ? 8'h00 : m_err) | err_set;
        @(posedge pclk);
        m_err = nxt;
        @(negedge pclk);
        err_set = (rand_err && ($urandom_range(0, 5) == 0)) ? 8'($urandom) : 8'h00;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_payload0"}, payload0, m_p0);
        check_eq({tag, "_payload1"}, payload1, m_p1);
        check_eq({tag, "_data_size"}, {24'd0, data_size}, {24'd0, m_ds});
    endtask

    task automatic xfer(input bit wr, input logic [1:0] wsel, input logic [1:0] rsel,
                        input logic [31:0] wd, input bit merr, input bit from_idle,
                        input bit next_follows, input logic [7:0] eset_c);
        int          waits;
        bit          serr, exp_err, clr;
        logic [31:0] exp_rd;
        if (from_idle) begin
            psel    = 1'b1;
            penable = 1'b0;
            check_eq("idle_pready", pready, 0);
            tick(0);
        end
        psel         = 1'b1;
        penable      = 1'b1;
        pwrite       = wr;
        write_select = wsel;
        read_select  = rsel;
        pwdata       = wd;
        map_err      = merr;
        check_eq("setup_pready", pready, 0);
        check_eq("setup_pslverr", pslverr, 0);
        tick(0);
        waits = 0;
        while (!pready) begin
            check_eq("wait_pslverr", pslverr, 0);
            check_eq("wait_prdata", prdata, 0);
            waits++;
            if (waits > 16) begin
                check_eq("pready_timeout", 0, 1);
                psel    = 1'b0;
                penable = 1'b0;
                tick(0);
                return;
            end
            tick(0);
        end
        check_eq("wait_count", waits, EXP_WAIT);
        serr    = wr && (wsel == 2'd2) && (wd > MAXS);
        exp_err = merr || serr;
        exp_rd  = (!wr && !merr) ? rd_model(rsel) : 32'd0;
        clr     = !wr && !merr && (rsel == 2'd0);
        check_eq("pslverr", pslverr, exp_err);
        check_eq("prdata", prdata, exp_rd);
        if (wr && !exp_err) begin
            case (wsel)
                2'd0:    m_p0 = wd;
                2'd1:    m_p1 = wd;
                2'd2:    m_ds = wd[7:0];
                default: ;
            endcase
        end
        if (eset_c != 8'h00) err_set = eset_c;
        psel    = next_follows;
        penable = 1'b0;
        tick(clr);
        check_regs("post");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    logic [1:0]  ws, rs;
    logic [31:0] wd;
    bit          wr, me, nf, chain;

    initial begin
        n_cmp = 0; n_bad = 0; rand_err = 0;
        m_p0 = 0; m_p1 = 0; m_ds = 0; m_err = 0;
        preset = 1'b1; psel = 0; penable = 0; pwrite = 0; pwdata = 0;
        write_select = 0; read_select = 0; map_err = 0; err_set = 0;
        repeat (3) @(negedge pclk);
        check_eq("rst_pready", pready, 0);
        check_eq("rst_pslverr", pslverr, 0);
        check_eq("rst_prdata", prdata, 0);
        check_regs("rst");
        preset = 1'b0;
        tick(0);

        // payload0 write then read, back to back
        xfer(1, 2'd0, 2'd0, 32'hDEADBEEF, 0, 1, 1, 8'h00);
        xfer(0, 2'd0, 2'd1, 32'h0, 0, 0, 0, 8'h00);
        check_eq("deadbeef_payload0", payload0, 32'hDEADBEEF);

        // data_size bounds
        xfer(1, 2'd2, 2'd0, 32'd5, 0, 1, 0, 8'h00);
        xfer(1, 2'd2, 2'd0, 32'd9, 0, 1, 0, 8'h00);
        check_eq("ds_after_9", {24'd0, data_size}, 32'd5);
        xfer(1, 2'd2, 2'd0, 32'd8, 0, 1, 1, 8'h00);
        xfer(0, 2'd0, 2'd3, 32'd0, 0, 0, 0, 8'h00);
        check_eq("ds_after_8", {24'd0, data_size}, 32'd8);

        // sticky status, clear on read, set wins over clear
        err_set = 8'h05;
        tick(0);
        xfer(0, 2'd0, 2'd0, 32'd0, 0, 1, 0, 8'h00);
        xfer(0, 2'd0, 2'd0, 32'd0, 0, 1, 0, 8'h00);
        err_set = 8'h04;
        tick(0);
        xfer(0, 2'd0, 2'd0, 32'd0, 0, 1, 0, 8'h01);
        xfer(0, 2'd0, 2'd0, 32'd0, 0, 1, 0, 8'h00);

        // decode error on read and on write, unmapped write target
        xfer(0, 2'd0, 2'd1, 32'd0, 1, 1, 0, 8'h00);
        xfer(1, 2'd1, 2'd0, 32'hCAFEF00D, 1, 1, 0, 8'h00);
        xfer(1, 2'd3, 2'd0, 32'h11112222, 0, 1, 0, 8'h00);

        // ACCESS without SETUP is ignored
        psel = 1; penable = 1; pwrite = 1; write_select = 2'd1; pwdata = 32'h0BADF00D; map_err = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("noset_pready", pready, 0);
            tick(0);
        end
        psel = 0; penable = 0;
        tick(0);
        check_regs("noset");

`ifdef APB_WAIT_STATES_EN
        // abort by dropping psel while waiting
        psel = 1; penable = 0;
        tick(0);
        psel = 1; penable = 1; pwrite = 1; write_select = 2'd1; pwdata = 32'hA5A5A5A5;
        tick(0);
        check_eq("abort_pready_access", pready, 0);
        psel = 0; penable = 0;
        tick(0);
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_pready_idle", pready, 0);
            tick(0);
        end
        check_regs("abort");
`endif

        // reset in the middle of ACCESS
        xfer(1, 2'd1, 2'd0, 32'h77778888, 0, 1, 0, 8'h00);
        psel = 1; penable = 0;
        tick(0);
        psel = 1; penable = 1; pwrite = 1; write_select = 2'd0; pwdata = 32'h12345678; map_err = 0;
        tick(0);
        preset = 1'b1;
        #1;
        m_p0 = 0; m_p1 = 0; m_ds = 0; m_err = 0;
        check_eq("midrst_pready", pready, 0);
        check_eq("midrst_pslverr", pslverr, 0);
        check_eq("midrst_prdata", prdata, 0);
        check_regs("midrst");
        psel = 0; penable = 0; err_set = 0;
        @(negedge pclk);
        preset = 1'b0;
        tick(0);
        xfer(0, 2'd0, 2'd0, 32'd0, 0, 1, 1, 8'h00);
        xfer(0, 2'd0, 2'd1, 32'd0, 0, 0, 0, 8'h00);

        // randomized traffic
        rand_err = 1;
        chain = 0;
        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            ws = 2'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3));
            wd = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12)) : $urandom;
            me = ($urandom_range(0, 7) == 0);
            nf = (i < 299) && ($urandom_range(0, 1) != 0);
            xfer(wr, ws, rs, wd, me, !chain, nf, 8'h00);
            chain = nf;
            if (!nf) begin
                repeat ($urandom_range(0, 2)) tick(0);
            end
        end
        rand_err = 0;
        tick(0);
        xfer(0, 2'd0, 2'd0, 32'd0, 0, 1, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_completer_regs.md
APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB data bus and payload register width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: ACCESS-phase wait states; used only under APB_WAIT_STATES_EN.
REQ-003 SHALL have parameter MAX_DATA_SIZE, default 8: largest legal data_size value, in bytes.
REQ-004 Clocking SHALL be: pclk  in  1  single clock, all state on rising edge.
REQ-005 Reset SHALL be: preset  in  1  asynchronous, active-high.
REQ-006 SHALL have: psel  in  1  completer select.
REQ-007 SHALL have: penable  in  1  APB access phase.
REQ-008 SHALL have: pwrite  in  1  1=write, 0=read.
REQ-009 SHALL have: pwdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have: write_select  in  2  decoded target from address map; 0=payload0, 1=payload1, 2=data_size.
REQ-011 SHALL have: read_select  in  2  decoded source; 0=err_status, 1=payload0, 2=payload1, 3=data_size.
REQ-012 SHALL have: map_err  in  1  decode error from address map.
REQ-013 SHALL have: err_set  in  8  core error pulses, one per status bit.
REQ-014 SHALL have: pready  out  1  transfer complete.
REQ-015 SHALL have: prdata  out  DATA_WIDTH  read data.
REQ-016 SHALL have: pslverr  out  1  transfer error.
REQ-017 SHALL have: payload0, payload1  out  DATA_WIDTH each  register contents to core.
REQ-018 SHALL have: data_size  out  8  register contents to core.

Function
REQ-019 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-020 IDLE->SETUP on psel&!penable; SETUP->ACCESS unconditionally; ACCESS->IDLE on pready&!psel; ACCESS->SETUP on pready&psel&!penable; ACCESS->IDLE on !psel before pready, with no commit.
REQ-021 psel&penable while in IDLE (no preceding SETUP) SHALL be ignored: state stays IDLE, pready=0.
REQ-022 pready SHALL be 1 in ACCESS when the wait count is 0, else 0; pready SHALL be 0 in IDLE and SETUP.
REQ-023 Completion cycle = ACCESS & pready; selects, pwdata and map_err SHALL be sampled only in that cycle.
REQ-024 Write commit SHALL occur at completion when pwrite=1 and no error; the register updates on that edge.
REQ-025 pslverr SHALL equal completion & (map_err | size_err); 0 in all other cycles.
REQ-026 size_err SHALL be set when the write targets data_size with pwdata > MAX_DATA_SIZE; data_size is then unchanged.
REQ-027 Writes to data_size SHALL store pwdata[7:0].
REQ-028 prdata SHALL be the selected register, zero-extended, at read completion without error; 0 otherwise.
REQ-029 err_status (8 bits) SHALL be sticky-set from err_set every cycle and cleared on a completed read of err_status.
REQ-030 When err_set and a clear-on-read hit the same cycle, set SHALL win for the bits pulsed; other bits clear.
REQ-031 Back-to-back transfers SHALL complete at one per 2 cycles without wait states.

Reset
REQ-032 On preset: state=IDLE, wait count=0, payload0=payload1=0, data_size=0, err_status=0, pready=0, pslverr=0, prdata=0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no commit; the first post-reset transfer SHALL start from SETUP.

Configuration
REQ-034 Macro APB_WAIT_STATES_EN SHALL gate wait states.
- Defined: count loaded with WAIT_CYCLES in SETUP, decremented each ACCESS cycle; pready asserts when the count reaches 0, so completion comes WAIT_CYCLES cycles after ACCESS entry.
- Undefined: count held at 0; pready=1 in the first ACCESS cycle.

Structure
REQ-035 Package apb_regs_pkg SHALL hold the state enum, write_select/read_select encodings and the err_status width.
REQ-036 Sub-module apb_wait_counter SHALL implement the wait count; instantiated only under APB_WAIT_STATES_EN.

Verification
REQ-037 Write payload0=0xDEADBEEF then read payload0 -> prdata=0xDEADBEEF, pslverr=0, 2-cycle transfers without macro.
REQ-038 Write data_size=9 -> pslverr=1 at completion, data_size stays previous value; write 8 -> data_size=8.
REQ-039 err_set=0x05, then read err_status -> prdata=0x05, then 0x00; err_set=0x01 on the clear cycle -> reads 0x01.
REQ-040 Macro defined, WAIT_CYCLES=2 -> pready low 2 ACCESS cycles, high on the 3rd; psel dropped before that -> no commit, IDLE.
REQ-041 map_err=1 on read -> pslverr=1, prdata=0; preset pulsed mid-ACCESS -> all registers 0, state IDLE.
